// File: rtl/pipeline_elastic.sv
// Elastic valid/ready register pipeline with NUM_STAGES stages and a combinational
// enable chain, so a full pipe can accept and emit on the same edge.
module pipeline_elastic #(
  parameter int unsigned NUM_BITS   = 16,
  parameter int unsigned NUM_STAGES = 1,
  parameter bit          EN_RESET   = 1'b0,
  localparam int unsigned OCC_W     = (NUM_STAGES == 0) ? 1 : $clog2(NUM_STAGES + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_in_valid,
  output logic                data_in_ready,
  output logic [NUM_BITS-1:0] data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic [OCC_W-1:0]    occupancy
);

  if (NUM_STAGES == 0) begin : g_bypass
    logic w_unused;
    assign w_unused       = ^{clk, rstn};
    assign data_out       = data_in;
    assign data_out_valid = data_in_valid;
    assign data_in_ready  = data_out_ready;
    assign occupancy      = '0;
  end else begin : g_pipe
    logic [NUM_STAGES:0]   w_en;
    logic [NUM_STAGES-1:0] w_vin;
    logic [NUM_BITS-1:0]   w_din [NUM_STAGES];
    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_BITS-1:0]   r_data [NUM_STAGES];
    logic [OCC_W-1:0]      w_occ;

    // A stage may advance if it is empty or the stage ahead of it advances.
    always_comb begin
      w_en             = '0;
      w_en[NUM_STAGES] = data_out_ready;
      for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
        w_en[k] = ~r_valid[k] | w_en[k+1];
      end
    end

    always_comb begin
      w_vin    = '0;
      w_vin[0] = data_in_valid;
      w_din[0] = data_in;
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        w_vin[k] = r_valid[k-1];
        w_din[k] = r_data[k-1];
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_valid <= '0;
      end else begin
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
          if (w_en[k]) r_valid[k] <= w_vin[k];
        end
      end
    end

    // Payload only loads for real items, so bubbles leave the contents untouched.
    if (EN_RESET) begin : g_data_rst
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < int'(NUM_STAGES); k++) r_data[k] <= '0;
        end else begin
          for (int k = 0; k < int'(NUM_STAGES); k++) begin
            if (w_en[k] && w_vin[k]) r_data[k] <= w_din[k];
          end
        end
      end
    end else begin : g_data_nrst
      always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
          if (w_en[k] && w_vin[k]) r_data[k] <= w_din[k];
        end
      end
    end

    always_comb begin
      w_occ = '0;
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        w_occ = w_occ + OCC_W'(r_valid[k]);
      end
    end

    assign data_in_ready  = w_en[0];
    assign data_out       = r_data[NUM_STAGES-1];
    assign data_out_valid = r_valid[NUM_STAGES-1];
    assign occupancy      = w_occ;
  end

endmodule

// File: tb/tb_pipeline_elastic.sv
// Bench for pipeline_elastic: six instances of different depth share one stimulus stream,
// each checked by its own FIFO scoreboard, plus directed vectors on the 3- and 4-stage copies.
module tb_pipeline_elastic;

  localparam int NDUT = 6;
  localparam int unsigned STAGES [NDUT] = '{3, 4, 0, 1, 2, 5};

  logic              clk = 1'b0;
  logic              rstn;
  logic [15:0]       din;
  logic              din_v;
  logic              dout_rdy;
  logic [NDUT-1:0]   dir;
  logic [NDUT-1:0]   dov;
  logic [15:0]       dout [NDUT];
  logic [7:0]        occ  [NDUT];

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] q [NDUT][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned S = STAGES[g];
    localparam int unsigned W = (S == 0) ? 1 : $clog2(S + 1);
    localparam bit ER = (g != 1);
    logic [W-1:0] w_occ;
    logic [15:0]  w_dout;
    pipeline_elastic #(
      .NUM_BITS  (16),
      .NUM_STAGES(S),
      .EN_RESET  (ER)
    ) u_dut (
      .clk           (clk),
      .rstn          (rstn),
      .data_in       (din),
      .data_in_valid (din_v),
      .data_in_ready (dir[g]),
      .data_out      (w_dout),
      .data_out_valid(dov[g]),
      .data_out_ready(dout_rdy),
      .occupancy     (w_occ)
    );
    assign dout[g] = w_dout;
    assign occ[g]  = 8'(w_occ);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accept pushes, every emit pops and compares.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NDUT; i++) q[i].delete();
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        if (din_v && dir[i]) q[i].push_back(din);
        if (dov[i] && dout_rdy) begin
          if (q[i].size() == 0) check($sformatf("sb_extra_item_dut%0d", i), 32'(q[i].size()), 1);
          else check($sformatf("sb_data_dut%0d", i), 32'(dout[i]), 32'(q[i].pop_front()));
        end
      end
      check("bypass_valid", 32'(dov[2]), 32'(din_v));
      check("bypass_ready", 32'(dir[2]), 32'(dout_rdy));
      check("bypass_occ", 32'(occ[2]), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_v    = 1'b0;
    dout_rdy = 1'b1;
    repeat (n) step();
  endtask

  typedef struct {
    logic        vin;
    logic [15:0] d;
    logic        rdy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_do;
    logic [7:0]  e_occ;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // inputs / expected state seen by the 3-stage instance before the edge
    tbl[0]  = '{1'b1, 16'h00A5, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd1};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00A5, 8'd1};
    tbl[4]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd0};
    tbl[5]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd1};
    tbl[6]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd2};
    tbl[7]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0001, 8'd3};
    tbl[8]  = '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0001, 8'd3};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0002, 8'd3};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 8'd2};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 8'd2};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0003, 8'd2};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0004, 8'd1};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd0};

    rstn = 1'b0; din = '0; din_v = 1'b0; dout_rdy = 1'b1;
    #2;
    check("reset_valid", 32'(dov[0]), 0);
    check("reset_occ", 32'(occ[0]), 0);
    check("reset_in_ready", 32'(dir[0]), 1);
    check("reset_data", 32'(dout[0]), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int r = 0; r < 15; r++) begin
      din_v = tbl[r].vin; din = tbl[r].d; dout_rdy = tbl[r].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", r), 32'(dir[0]), 32'(tbl[r].e_ir));
      check($sformatf("vec%0d_out_valid", r), 32'(dov[0]), 32'(tbl[r].e_ov));
      check($sformatf("vec%0d_occ", r), 32'(occ[0]), 32'(tbl[r].e_occ));
      if (tbl[r].e_ov) check($sformatf("vec%0d_data", r), 32'(dout[0]), 32'(tbl[r].e_do));
      step();
    end

    // Back-to-back stream through the 3-stage copy.
    idle(8);
    for (int c = 0; c < 13; c++) begin
      din_v = (c < 10); din = 16'(c); dout_rdy = 1'b1;
      @(negedge clk);
      if (c >= 3) begin
        check($sformatf("stream%0d_valid", c), 32'(dov[0]), 1);
        check($sformatf("stream%0d_data", c), 32'(dout[0]), 32'(c - 3));
      end
      if (c >= 3 && c <= 9) check($sformatf("stream%0d_occ", c), 32'(occ[0]), 3);
      step();
    end

    // Fill the 4-stage copy against a stalled sink.
    idle(8);
    dout_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      din_v = 1'b1; din = 16'h0010 + 16'(k);
      @(negedge clk);
      check($sformatf("fill%0d_in_ready", k), 32'(dir[1]), 32'(k < 4));
      if (k >= 4) check($sformatf("fill%0d_held_data", k), 32'(dout[1]), 32'h10);
      step();
    end
    din_v = 1'b0;
    @(negedge clk);
    check("full_occ", 32'(occ[1]), 4);
    check("full_valid", 32'(dov[1]), 1);
    check("full_data", 32'(dout[1]), 32'h10);
    check("full_in_ready", 32'(dir[1]), 0);
    step();
    idle(10);

    // Asynchronous reset with items in flight in the 3-stage copy.
    idle(8);
    dout_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din_v = 1'b1; din = 16'h0021 + 16'(k);
      step();
    end
    din_v = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("midrst_valid", 32'(dov[0]), 0);
    check("midrst_data", 32'(dout[0]), 0);
    check("midrst_occ", 32'(occ[0]), 0);
    check("midrst_in_ready", 32'(dir[0]), 1);
    @(posedge clk);
    #1 rstn = 1'b1;
    dout_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("postrst%0d_valid", k), 32'(dov[0]), 0);
      step();
    end

    // Random valid/ready traffic, all depths.
    for (int n = 0; n < 10000; n++) begin
      din_v    = ($urandom_range(0, 3) != 0);
      dout_rdy = ($urandom_range(0, 2) != 0);
      din      = 16'($urandom);
      step();
    end

    idle(20);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("drain_dut%0d_left", i), 32'(q[i].size()), 0);
      check($sformatf("drain_dut%0d_occ", i), 32'(occ[i]), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
